// File: rtl/bcd_updown_counter.sv
// ---------------------------------------------------------------------------
// bcd_updown_counter
//
// Multi-decade BCD up/down counter with synchronous parallel load.
// The whole counter advances in a single clock edge: each decade is
// computed combinationally from the lower decades, so there is no ripple
// delay between digits.
//
// Build option:
//   BCD_CNT_SAT_EN  - when defined, the counter saturates at all-9s
//                     (counting up) and at 0 (counting down), and wrap is
//                     tied low. When undefined, the counter wraps around.
//
// Parameters:
//   DIGITS    - number of BCD decades (1..8)
//
// Ports:
//   clk       - clock; all state changes on the rising edge
//   rst       - synchronous active-high reset (q, wrap, err -> 0)
//   en        - count enable, one step per edge while high
//   up        - direction: 1 = increment, 0 = decrement
//   load      - synchronous load strobe (takes priority over en)
//   load_val  - BCD value to load, digit 0 in bits [3:0]; nibbles above 9
//               are loaded as 0
//   q         - registered BCD count, digit 0 least significant
//   tc        - combinational terminal count: all-9s when counting up,
//               zero when counting down
//   wrap      - registered one-cycle pulse after a count step that wrapped
//   err       - registered one-cycle pulse after a load that contained an
//               invalid (greater than 9) nibble
// ---------------------------------------------------------------------------
module bcd_updown_counter #(
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   q,
    output logic                  tc,
    output logic                  wrap,
    output logic                  err
);

    localparam int unsigned W = 4 * DIGITS;

    // State
    logic [W-1:0] cnt_q, cnt_d;
    logic         wrap_q, wrap_d;
    logic         err_q, err_d;

    // Combinational helpers
    logic [W-1:0] load_clean;
    logic         load_bad;
    logic         all_nine;
    logic         all_zero;
    logic [W-1:0] inc_val;
    logic [W-1:0] dec_val;

    // -----------------------------------------------------------------------
    // Load sanitising: any nibble above 9 is replaced by 0 and flagged.
    // -----------------------------------------------------------------------
    always_comb begin : load_sanitize
        load_clean = '0;
        load_bad   = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (load_val[4*i +: 4] > 4'd9) begin
                load_bad = 1'b1;
            end else begin
                load_clean[4*i +: 4] = load_val[4*i +: 4];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Limit detection on the current count.
    // -----------------------------------------------------------------------
    always_comb begin : limit_detect
        all_nine = 1'b1;
        all_zero = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (cnt_q[4*i +: 4] != 4'd9) begin
                all_nine = 1'b0;
            end
            if (cnt_q[4*i +: 4] != 4'd0) begin
                all_zero = 1'b0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Increment: a carry enters digit 0 and propagates through every digit
    // that is at 9. From all-9s the carry falls off the top, giving 0.
    // -----------------------------------------------------------------------
    always_comb begin : increment
        logic carry;
        inc_val = cnt_q;
        carry   = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (cnt_q[4*i +: 4] == 4'd9) begin
                    inc_val[4*i +: 4] = 4'd0;
                end else begin
                    inc_val[4*i +: 4] = cnt_q[4*i +: 4] + 4'd1;
                    carry             = 1'b0;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Decrement: a borrow enters digit 0 and propagates through every digit
    // that is at 0. From zero the borrow falls off the top, giving all-9s.
    // -----------------------------------------------------------------------
    always_comb begin : decrement
        logic borrow;
        dec_val = cnt_q;
        borrow  = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (cnt_q[4*i +: 4] == 4'd0) begin
                    dec_val[4*i +: 4] = 4'd9;
                end else begin
                    dec_val[4*i +: 4] = cnt_q[4*i +: 4] - 4'd1;
                    borrow            = 1'b0;
                end
            end
        end
    end

    // Terminal count doubles as "the next step in this direction wraps".
    assign tc = up ? all_nine : all_zero;

    // -----------------------------------------------------------------------
    // Next state: load beats count; reset is applied in the register.
    // -----------------------------------------------------------------------
    always_comb begin : next_state
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        err_d  = 1'b0;
        if (load) begin
            cnt_d = load_clean;
            err_d = load_bad;
        end else if (en) begin
`ifdef BCD_CNT_SAT_EN
            if (!tc) begin
                cnt_d = up ? inc_val : dec_val;
            end
`else
            cnt_d  = up ? inc_val : dec_val;
            wrap_d = tc;
`endif
        end
    end

    always_ff @(posedge clk) begin : state_reg
        if (rst) begin
            cnt_q  <= '0;
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
            err_q  <= err_d;
        end
    end

    assign q    = cnt_q;
    assign wrap = wrap_q;
    assign err  = err_q;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// ---------------------------------------------------------------------------
// tb_bcd_updown_counter
//
// Scoreboard bench for bcd_updown_counter with DIGITS=2. A decimal
// reference model produces the expected {q, wrap, err} for every driven
// cycle and pushes it to a queue; each scenario task pops and compares after
// the clock edge. A negedge monitor checks tc and nibble legality every
// cycle. Define BCD_CNT_SAT_EN for both DUT and bench to check the
// saturating build.
// ---------------------------------------------------------------------------
module tb_bcd_updown_counter;

    localparam int D    = 2;
    localparam int MAXV = 99;

    logic           clk = 1'b0;
    logic           rst;
    logic           en;
    logic           up;
    logic           load;
    logic [4*D-1:0] load_val;
    logic [4*D-1:0] q;
    logic           tc;
    logic           wrap;
    logic           err;

    always #5 clk = ~clk;

    bcd_updown_counter #(.DIGITS(D)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_val (load_val),
        .q        (q),
        .tc       (tc),
        .wrap     (wrap),
        .err      (err)
    );

    typedef struct packed {
        logic [4*D-1:0] q;
        logic           wrap;
        logic           err;
    } exp_t;

    typedef struct packed {
        logic           r;
        logic           l;
        logic [4*D-1:0] lv;
        logic           e;
        logic           u;
    } stim_t;

    exp_t           sb[$];
    int             model;
    int             tests_run = 0;
    int             fails     = 0;
    logic [4*D-1:0] cur_q;
    bit             model_valid = 1'b0;

    function automatic logic [4*D-1:0] to_bcd(input int v);
        logic [4*D-1:0] r;
        int             t;
        r = '0;
        t = v;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic int from_load(input logic [4*D-1:0] lv, output bit bad);
        int v;
        int mul;
        v   = 0;
        mul = 1;
        bad = 1'b0;
        for (int i = 0; i < D; i++) begin
            if (lv[4*i +: 4] > 4'd9) bad = 1'b1;
            else v = v + int'(lv[4*i +: 4]) * mul;
            mul = mul * 10;
        end
        return v;
    endfunction

    // Drive one cycle of stimulus, predict the result, advance past the edge.
    task automatic drive(input stim_t s);
        exp_t x;
        bit   bad;
        rst      = s.r;
        load     = s.l;
        load_val = s.lv;
        en       = s.e;
        up       = s.u;
        x.wrap   = 1'b0;
        x.err    = 1'b0;
        if (s.r) begin
            model = 0;
        end else if (s.l) begin
            model = from_load(s.lv, bad);
            x.err = bad;
        end else if (s.e) begin
            if (s.u) begin
                if (model == MAXV) begin
`ifndef BCD_CNT_SAT_EN
                    model  = 0;
                    x.wrap = 1'b1;
`endif
                end else begin
                    model = model + 1;
                end
            end else begin
                if (model == 0) begin
`ifndef BCD_CNT_SAT_EN
                    model  = MAXV;
                    x.wrap = 1'b1;
`endif
                end else begin
                    model = model - 1;
                end
            end
        end
        x.q = to_bcd(model);
        sb.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic get_exp(output exp_t x, output bit ok);
        ok = (sb.size() != 0);
        if (ok) begin
            x     = sb.pop_front();
            cur_q = x.q;
        end else begin
            x = '0;
        end
    endtask

    // Every-cycle checks: tc against the model, nibbles of q within 0..9.
    always @(negedge clk) begin
        if (model_valid) begin
            logic tc_exp;
            bit   badn;
            tc_exp = up ? (cur_q == to_bcd(MAXV)) : (cur_q == '0);
            tests_run++;
            if (tc !== tc_exp) begin
                fails++;
                $display("FAIL tc_monitor t=%0t q=%h up=%b tc=%b expected %b",
                         $time, q, up, tc, tc_exp);
            end
            badn = $isunknown(q);
            for (int i = 0; i < D; i++) begin
                if (q[4*i +: 4] > 4'd9) badn = 1'b1;
            end
            tests_run++;
            if (badn) begin
                fails++;
                $display("FAIL nibble_legal t=%0t q=%h expected every nibble <= 9",
                         $time, q);
            end
        end
    end

    task automatic test_reset();
        exp_t x;
        bit   ok;
        for (int k = 0; k < 2; k++) begin
            drive('{r: 1'b1, l: 1'b1, lv: 8'h42, e: 1'b1, u: 1'b0});
            get_exp(x, ok);
            model_valid = 1'b1;
            tests_run++;
            if (!ok || {q, wrap, err} !== {x.q, x.wrap, x.err}) begin
                fails++;
                $display("FAIL reset k=%0d q=%h wrap=%b err=%b expected q=%h wrap=%b err=%b",
                         k, q, wrap, err, x.q, x.wrap, x.err);
            end
        end
        tests_run++;
        if (tc !== 1'b1) begin
            fails++;
            $display("FAIL reset_tc tc=%b expected 1", tc);
        end
    endtask

    task automatic test_count_up();
        exp_t x;
        bit   ok;
        int   wraps;
        wraps = 0;
        for (int k = 0; k < 100; k++) begin
            drive('{r: 1'b0, l: 1'b0, lv: 8'h00, e: 1'b1, u: 1'b1});
            get_exp(x, ok);
            if (wrap === 1'b1) wraps++;
            tests_run++;
            if (!ok || {q, wrap, err} !== {x.q, x.wrap, x.err}) begin
                fails++;
                $display("FAIL count_up k=%0d q=%h wrap=%b err=%b expected q=%h wrap=%b err=%b",
                         k, q, wrap, err, x.q, x.wrap, x.err);
            end
        end
        tests_run++;
`ifdef BCD_CNT_SAT_EN
        if (wraps != 0) begin
            fails++;
            $display("FAIL count_up_wraps got %0d expected 0", wraps);
        end
`else
        if (wraps != 1) begin
            fails++;
            $display("FAIL count_up_wraps got %0d expected 1", wraps);
        end
`endif
    endtask

    task automatic test_load_borrow();
        exp_t  x;
        bit    ok;
        stim_t s[3];
        s[0] = '{r: 1'b0, l: 1'b1, lv: 8'h30, e: 1'b0, u: 1'b0};
        s[1] = '{r: 1'b0, l: 1'b0, lv: 8'h00, e: 1'b1, u: 1'b0};
        s[2] = '{r: 1'b0, l: 1'b0, lv: 8'h00, e: 1'b1, u: 1'b0};
        for (int k = 0; k < 3; k++) begin
            drive(s[k]);
            get_exp(x, ok);
            tests_run++;
            if (!ok || {q, wrap, err} !== {x.q, x.wrap, x.err}) begin
                fails++;
                $display("FAIL load_borrow k=%0d q=%h wrap=%b err=%b expected q=%h wrap=%b err=%b",
                         k, q, wrap, err, x.q, x.wrap, x.err);
            end
        end
    endtask

    task automatic test_load_err();
        exp_t  x;
        bit    ok;
        stim_t s[6];
        s[0] = '{r: 1'b0, l: 1'b1, lv: 8'h9A, e: 1'b0, u: 1'b1};
        s[1] = '{r: 1'b0, l: 1'b0, lv: 8'h9A, e: 1'b0, u: 1'b1};
        s[2] = '{r: 1'b0, l: 1'b1, lv: 8'h45, e: 1'b1, u: 1'b1};
        s[3] = '{r: 1'b0, l: 1'b1, lv: 8'hFF, e: 1'b1, u: 1'b0};
        s[4] = '{r: 1'b0, l: 1'b1, lv: 8'h99, e: 1'b1, u: 1'b1};
        s[5] = '{r: 1'b0, l: 1'b1, lv: 8'h00, e: 1'b1, u: 1'b0};
        for (int k = 0; k < 6; k++) begin
            drive(s[k]);
            get_exp(x, ok);
            tests_run++;
            if (!ok || {q, wrap, err} !== {x.q, x.wrap, x.err}) begin
                fails++;
                $display("FAIL load_err k=%0d q=%h wrap=%b err=%b expected q=%h wrap=%b err=%b",
                         k, q, wrap, err, x.q, x.wrap, x.err);
            end
        end
    endtask

    task automatic test_reset_mid();
        exp_t  x;
        bit    ok;
        stim_t s[5];
        s[0] = '{r: 1'b0, l: 1'b1, lv: 8'h57, e: 1'b0, u: 1'b1};
        s[1] = '{r: 1'b1, l: 1'b1, lv: 8'h88, e: 1'b1, u: 1'b1};
        s[2] = '{r: 1'b0, l: 1'b0, lv: 8'h00, e: 1'b1, u: 1'b1};
        s[3] = '{r: 1'b0, l: 1'b0, lv: 8'h00, e: 1'b1, u: 1'b1};
        s[4] = '{r: 1'b0, l: 1'b0, lv: 8'h00, e: 1'b0, u: 1'b1};
        for (int k = 0; k < 5; k++) begin
            drive(s[k]);
            get_exp(x, ok);
            tests_run++;
            if (!ok || {q, wrap, err} !== {x.q, x.wrap, x.err}) begin
                fails++;
                $display("FAIL reset_mid k=%0d q=%h wrap=%b err=%b expected q=%h wrap=%b err=%b",
                         k, q, wrap, err, x.q, x.wrap, x.err);
            end
        end
    endtask

    task automatic test_wrap_down();
        exp_t  x;
        bit    ok;
        stim_t s[6];
        s[0] = '{r: 1'b1, l: 1'b0, lv: 8'h00, e: 1'b0, u: 1'b0};
        s[1] = '{r: 1'b0, l: 1'b0, lv: 8'h00, e: 1'b1, u: 1'b0};
        s[2] = '{r: 1'b0, l: 1'b0, lv: 8'h00, e: 1'b1, u: 1'b1};
        s[3] = '{r: 1'b0, l: 1'b1, lv: 8'h99, e: 1'b0, u: 1'b1};
        s[4] = '{r: 1'b0, l: 1'b0, lv: 8'h00, e: 1'b1, u: 1'b1};
        s[5] = '{r: 1'b0, l: 1'b0, lv: 8'h00, e: 1'b1, u: 1'b0};
        for (int k = 0; k < 6; k++) begin
            drive(s[k]);
            get_exp(x, ok);
            tests_run++;
            if (!ok || {q, wrap, err} !== {x.q, x.wrap, x.err}) begin
                fails++;
                $display("FAIL wrap_down k=%0d q=%h wrap=%b err=%b expected q=%h wrap=%b err=%b",
                         k, q, wrap, err, x.q, x.wrap, x.err);
            end
        end
    endtask

    // Random mix of loads, direction flips, holds and occasional resets.
    task automatic test_back_to_back();
        exp_t  x;
        bit    ok;
        stim_t s;
        for (int k = 0; k < 200; k++) begin
            s.r  = ($urandom_range(0, 29) == 0);
            s.l  = ($urandom_range(0, 4) == 0);
            s.lv = 8'($urandom);
            s.e  = ($urandom_range(0, 3) != 0);
            s.u  = 1'($urandom);
            drive(s);
            get_exp(x, ok);
            tests_run++;
            if (!ok || {q, wrap, err} !== {x.q, x.wrap, x.err}) begin
                fails++;
                $display("FAIL back_to_back k=%0d q=%h wrap=%b err=%b expected q=%h wrap=%b err=%b",
                         k, q, wrap, err, x.q, x.wrap, x.err);
            end
        end
    endtask

    initial begin
        rst      = 1'b1;
        en       = 1'b0;
        up       = 1'b0;
        load     = 1'b0;
        load_val = '0;
        model    = 0;
        cur_q    = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_count_up();
        test_load_borrow();
        test_load_err();
        test_reset_mid();
        test_wrap_down();
        test_back_to_back();
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/bcd_updown_counter.md
BCD_UPDOWN_COUNTER -- requirements
Module: bcd_updown_counter

Interface
REQ-001 Parameter DIGITS, default 4: number of BCD decades; legal range 1..8.
REQ-002 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 Port rst, input, 1: reset, synchronous and active-high.
REQ-004 Port en, input, 1: count enable; one step per clk edge while high.
REQ-005 Port up, input, 1: direction; 1 = increment, 0 = decrement.
REQ-006 Port load, input, 1: synchronous parallel load strobe.
REQ-007 Port load_val, input, 4*DIGITS: BCD value to load; digit 0 is bits [3:0].
REQ-008 Port q, output, 4*DIGITS: registered count, one BCD digit per nibble, digit 0 least significant.
REQ-009 Port tc, output, 1: terminal count, combinational; high when (up=1 and every digit of q is 9) or (up=0 and q=0).
REQ-010 Port wrap, output, 1: registered; one-cycle pulse in the cycle after a count step crossed all-9s to 0 or 0 to all-9s.
REQ-011 Port err, output, 1: registered; one-cycle pulse in the cycle after a load containing any nibble greater than 9.

Function
REQ-012 Priority per edge: rst > load > en; when none is active, q holds.
REQ-013 Load: q takes load_val on the edge, with each nibble greater than 9 replaced by 0; err is 1 for the following cycle only if at least one nibble was replaced.
REQ-014 Increment: digit 0 steps 0..9; digit k advances only when digits 0..k-1 are all 9; a digit at 9 that advances goes to 0.
REQ-015 Decrement: digit 0 steps 9..0; digit k changes only when digits 0..k-1 are all 0; a digit at 0 that changes goes to 9.
REQ-016 Full-range step: the whole counter updates in one edge, so count latency is one cycle; there is no ripple delay between digits.
REQ-017 Wrap: increment from all-9s gives 0; decrement from 0 gives all-9s; wrap pulses for one cycle after either transition.
REQ-018 A direction change takes effect on the same edge that samples it; there is no pipeline or turnaround cycle.
REQ-019 Simultaneous load and en: load wins, no count step occurs, and wrap stays 0.
REQ-020 q never holds a nibble greater than 9 after any reset, load or count.
REQ-021 wrap and err are 0 in every cycle not covered by REQ-013 or REQ-017.

Reset
REQ-022 When rst is sampled high: q becomes 0, wrap becomes 0 and err becomes 0 on that edge.
REQ-023 Reset asserted mid-count overrides load and en; counting resumes from 0 on the first edge after rst is low.
REQ-024 tc follows q and up combinationally, including during reset; after reset with up=0, tc=1.

Configuration
REQ-025 Macro BCD_CNT_SAT_EN selects saturating mode when defined.
REQ-026 With BCD_CNT_SAT_EN defined: an increment at all-9s holds all-9s, a decrement at 0 holds 0, and wrap is tied to 0.
REQ-027 With BCD_CNT_SAT_EN undefined: wrap-around behaviour per REQ-017 applies.
REQ-028 All other behaviour is identical in both builds.

Verification (DIGITS=2)
REQ-029 Reset then en=1, up=1 for 100 edges -> q counts 00,01..09,10..99,00; wrap=1 for exactly one cycle after 99->00; tc=1 while q=99.
REQ-030 load_val=8'h30, then en=1, up=0 for 2 edges -> q=30,29,28; digit 0 borrow into digit 1 is correct.
REQ-031 load_val=8'h9A -> q=90, err pulses 1 for one cycle; load=1 and en=1 on the same edge -> load wins and no step occurs.
REQ-032 rst asserted while q=57 and en=1 -> q=00 on that edge, wrap=0, err=0; counting resumes from 00 after rst is low.
REQ-033 q=00, up=0, en=1 for 1 edge -> without the macro q=99 and wrap pulses; with BCD_CNT_SAT_EN q stays 00 and wrap stays 0.
REQ-034 Every cycle of every scenario: checker confirms each nibble of q is 9 or less and tc matches REQ-009.
